// File: rtl/link_rx_buffer.sv
// Receive-side link buffer: DEPTH-entry FIFO toward the router with one credit pulse per freed flit.
// Optional same-cycle empty-FIFO bypass enabled by defining LINK_RX_BYPASS_EN.
`ifndef FLIT_SIZE
`define FLIT_SIZE 8
`endif

module link_rx_buffer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     link_flit_valid,
    input  logic [`FLIT_SIZE-1:0]    link_flit,
    output logic                     out_valid,
    output logic [`FLIT_SIZE-1:0]    out_flit,
    input  logic                     out_ready,
    output logic                     credit_return,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow
);

    localparam int unsigned FW = `FLIT_SIZE;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [FW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic empty_c;
    logic full_c;
    logic bypass_c;
    logic pop_c;
    logic push_c;
    logic drop_c;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty_c   = (wr_ptr == rd_ptr);
    assign full_c    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign occupancy = wr_ptr - rd_ptr;

    always_comb begin
        bypass_c  = 1'b0;
`ifdef LINK_RX_BYPASS_EN
        bypass_c  = empty_c && link_flit_valid && out_ready;
`endif
        out_valid = !empty_c || bypass_c;
        out_flit  = empty_c ? FW'(0) : mem[rd_ptr[AW-1:0]];
        if (bypass_c) begin
            out_flit = link_flit;
        end
        pop_c  = out_valid && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_c = link_flit_valid && !bypass_c && (!full_c || pop_c);
        drop_c = link_flit_valid && full_c && !pop_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= PW'(0);
            rd_ptr        <= PW'(0);
            credit_return <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c && !bypass_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            credit_return <= pop_c;
            overflow      <= overflow || drop_c;
        end
    end

    // Storage needs no reset; reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr[AW-1:0]] <= link_flit;
        end
    end

endmodule

// File: tb/tb_link_rx_buffer.sv
// Scoreboard bench for link_rx_buffer: expected flits queued on acceptance, compared at the head each cycle.
`ifndef FLIT_SIZE
`define FLIT_SIZE 8
`endif

module tb_link_rx_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned FW    = `FLIT_SIZE;
    localparam int unsigned OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          link_flit_valid = 1'b0;
    logic [FW-1:0] link_flit = '0;
    logic          out_valid;
    logic [FW-1:0] out_flit;
    logic          out_ready = 1'b0;
    logic          credit_return;
    logic [OW-1:0] occupancy;
    logic          overflow;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cred_seen = 0;
    int unsigned pops = 0;
    logic [FW-1:0] sb_q[$];
    logic          m_credit = 1'b0;
    logic          m_ovf = 1'b0;

    link_rx_buffer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .link_flit_valid (link_flit_valid),
        .link_flit       (link_flit),
        .out_valid       (out_valid),
        .out_flit        (out_flit),
        .out_ready       (out_ready),
        .credit_return   (credit_return),
        .occupancy       (occupancy),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check against the model, advance the model.
    task automatic step(input logic v, input logic [FW-1:0] f, input logic rdy);
        logic byp, exp_valid, pop, push;
        link_flit_valid = v;
        link_flit       = f;
        out_ready       = rdy;
        #1;
        byp = 1'b0;
`ifdef LINK_RX_BYPASS_EN
        byp = (sb_q.size() == 0) && v && rdy;
`endif
        exp_valid = (sb_q.size() != 0) || byp;
        check("valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) check("flit", 32'(out_flit), byp ? 32'(f) : 32'(sb_q[0]));
        check("occ", 32'(occupancy), 32'(sb_q.size()));
        check("credit", 32'(credit_return), 32'(m_credit));
        check("ovf", 32'(overflow), 32'(m_ovf));
        cred_seen += 32'(credit_return);
        pop  = exp_valid && rdy;
        push = v && !byp && ((sb_q.size() < DEPTH) || pop);
        if (pop && !byp) void'(sb_q.pop_front());
        if (push) sb_q.push_back(f);
        if (v && !byp && !push) m_ovf = 1'b1;
        m_credit = pop;
        if (pop) pops++;
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_flit"}, 32'(out_flit), 32'd0);
        check({tag, "_occ"}, 32'(occupancy), 32'd0);
        check({tag, "_credit"}, 32'(credit_return), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #2;
        check_zero("rst_init");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Streaming, one flit per cycle.
        cred_seen = 0;
        for (int i = 1; i <= 20; i++) step(1'b1, FW'(i), 1'b1);
        repeat (2) step(1'b0, '0, 1'b1);
        check("stream_credits", cred_seen, 32'd20);

        // Fill while stalled, then drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, FW'(8'h30 + i), 1'b0);
        step(1'b0, '0, 1'b0);
        check("fill_occ", 32'(occupancy), 32'(DEPTH));
        cred_seen = 0;
        repeat (DEPTH + 2) step(1'b0, '0, 1'b1);
        check("drain_credits", cred_seen, 32'(DEPTH));
        check("drain_occ", 32'(occupancy), 32'd0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) step(1'b1, FW'(8'h40 + i), 1'b0);
        cred_seen = 0;
        for (int i = 0; i < 5; i++) step(1'b1, FW'(8'h60 + i), 1'b1);
        step(1'b0, '0, 1'b0);
        check("fullpp_occ", 32'(occupancy), 32'(DEPTH));
        check("fullpp_ovf", 32'(overflow), 32'd0);
        check("fullpp_credits", cred_seen, 32'd5);

        // Overflow: extra flit dropped, flag sticky.
        step(1'b1, FW'(8'hAA), 1'b0);
        repeat (2) step(1'b0, '0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_occ", 32'(occupancy), 32'(DEPTH));
        repeat (DEPTH + 2) step(1'b0, '0, 1'b1);

        // Reset mid-burst with flits stored and a credit pending.
        for (int i = 0; i < 4; i++) step(1'b1, FW'(8'h70 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        #1;
        check("pre_rst_credit", 32'(credit_return), 32'd1);
        check("pre_rst_occ", 32'(occupancy), 32'd3);
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        check_zero("rst_hold");
        rst = 1'b1;
        sb_q.delete();
        m_credit = 1'b0;
        m_ovf    = 1'b0;
        step(1'b1, FW'(8'h77), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

`ifdef LINK_RX_BYPASS_EN
        step(1'b1, FW'(8'h55), 1'b1);
        step(1'b0, '0, 1'b0);
`endif

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), FW'($urandom), 1'($urandom_range(0, 2) != 0));
        repeat (DEPTH + 2) step(1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
